// File: rtl/cpu_ctrl_pkg.sv
// Shared controller definitions: opcodes, ALU-op codes, FSM states,
// instruction classes and the bundle of datapath control strobes.
package cpu_ctrl_pkg;

  localparam int CPU_WORD_W = 32;
  localparam int CPU_OP_W   = 5;

  // Opcode map (ir[31:27])
  localparam logic [CPU_OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [CPU_OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [CPU_OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [CPU_OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [CPU_OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [CPU_OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [CPU_OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [CPU_OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [CPU_OP_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [CPU_OP_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [CPU_OP_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [CPU_OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [CPU_OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [CPU_OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [CPU_OP_W-1:0] OP_DIV  = 5'b01110;
  localparam logic [CPU_OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [CPU_OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [CPU_OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [CPU_OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [CPU_OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [CPU_OP_W-1:0] OP_IN   = 5'b10100;
  localparam logic [CPU_OP_W-1:0] OP_OUT  = 5'b10101;
  localparam logic [CPU_OP_W-1:0] OP_MFHI = 5'b10110;
  localparam logic [CPU_OP_W-1:0] OP_MFLO = 5'b10111;
  localparam logic [CPU_OP_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [CPU_OP_W-1:0] OP_HALT = 5'b11001;

  // ALU operation codes used internally for address/immediate arithmetic
  localparam logic [CPU_OP_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [CPU_OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [CPU_OP_W-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALUR, CL_ALUI, CL_MULDIV, CL_UNARY, CL_BR,
    CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } instr_class_t;

  typedef struct packed {
    logic                pc_out;
    logic                zlow_out;
    logic                zhigh_out;
    logic                mdr_out;
    logic                hi_out;
    logic                lo_out;
    logic                inport_out;
    logic                ba_out;
    logic                c_out;
    logic                r_out;
    logic                mar_en;
    logic                pc_en;
    logic                mdr_en;
    logic                mdr_read;
    logic                ir_en;
    logic                y_en;
    logic                zlow_in;
    logic                zhigh_in;
    logic                hi_en;
    logic                lo_en;
    logic                r_in;
    logic                con_en;
    logic                outport_en;
    logic                ram_write;
    logic                inc_pc;
    logic                gra;
    logic                grb;
    logic                grc;
    logic [CPU_OP_W-1:0] op;
  } ctrl_t;

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational opcode-to-class map; unlisted opcodes behave as nop.
module instr_class_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [CPU_OP_W-1:0] op_i,
  output instr_class_t        class_o
);

  // Classify the opcode field
  always_comb begin
    class_o = CL_NOP;
    case (op_i)
      OP_LD:   class_o = CL_LD;
      OP_LDI:  class_o = CL_LDI;
      OP_ST:   class_o = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL:
               class_o = CL_ALUR;
      OP_ADDI, OP_ANDI, OP_ORI:
               class_o = CL_ALUI;
      OP_DIV, OP_MUL:
               class_o = CL_MULDIV;
      OP_NEG, OP_NOT:
               class_o = CL_UNARY;
      OP_BR:   class_o = CL_BR;
      OP_JR:   class_o = CL_JR;
      OP_IN:   class_o = CL_IN;
      OP_OUT:  class_o = CL_OUT;
      OP_MFHI: class_o = CL_MFHI;
      OP_MFLO: class_o = CL_MFLO;
      OP_HALT: class_o = CL_HALT;
      default: class_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle controller: fetch T0-T2, class-dependent execute
// T3-T7, Moore outputs decoded from the step register and the latched IR.
//
// state   | meaning
// RESET   | held by clr, all outputs low
// T0      | PC -> MAR, PC+1 -> Z
// T1      | Z -> PC, memory -> MDR
// T2      | MDR -> IR
// T3..T7  | execute steps, length depends on instruction class
// HALT    | stopped until clr, all outputs low
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int OP_W   = CPU_OP_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] ir,
  input  logic              con_ff,
  output logic [OP_W-1:0]   opCode,
  output logic              PCout,
  output logic              ZLowout,
  output logic              ZHighout,
  output logic              MDRout,
  output logic              HIout,
  output logic              LOout,
  output logic              InPortout,
  output logic              BAout,
  output logic              Cout,
  output logic              R_out,
  output logic              MAR_enable,
  output logic              PC_enable,
  output logic              MDR_enable,
  output logic              MDR_read,
  output logic              IR_enable,
  output logic              Y_enable,
  output logic              ZLowIn,
  output logic              ZHighIn,
  output logic              HI_enable,
  output logic              LO_enable,
  output logic              R_in,
  output logic              CON_enable,
  output logic              OutPort_enable,
  output logic              RAM_write,
  output logic              IncPC,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              run
);

  state_t                state_q, state_d;
  instr_class_t          cls;
  ctrl_t                 ctrl;
  logic [CPU_OP_W-1:0]   opc;
  logic [CPU_OP_W-1:0]   imm_op;
  logic                  unused_ir_bits;

  assign opc            = ir[WORD_W-1 -: OP_W];
  assign unused_ir_bits = ^ir[WORD_W-OP_W-1:0];

  instr_class_decoder u_dec (
    .op_i    (opc),
    .class_o (cls)
  );

  assign imm_op = (opc == OP_ADDI) ? ALU_ADD :
                  (opc == OP_ANDI) ? ALU_AND : ALU_OR;

  // Step register; clr wins over any in-flight step
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // Step sequencing: the final step of each class returns to T0
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST, CL_ALUR, CL_ALUI,
          CL_MULDIV, CL_UNARY, CL_BR: state_d = ST_T4;
          CL_HALT:                    state_d = ST_HALT;
          default:                    state_d = ST_T0;
        endcase
      end
      ST_T4:    state_d = (cls == CL_UNARY) ? ST_T0 : ST_T5;
      ST_T5:    state_d = (cls inside {CL_LDI, CL_ALUR, CL_ALUI}) ? ST_T0 : ST_T6;
      ST_T6:    state_d = (cls inside {CL_MULDIV, CL_BR}) ? ST_T0 : ST_T7;
      ST_T7:    state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Control-word decode per step and instruction class
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      ST_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_en = 1'b1; ctrl.inc_pc = 1'b1; ctrl.zlow_in = 1'b1;
      end
      ST_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_en = 1'b1; ctrl.mdr_read = 1'b1; ctrl.mdr_en = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_en = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_en = 1'b1; end
          CL_ALUR, CL_ALUI:     begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_en = 1'b1; end
          CL_MULDIV:            begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_en = 1'b1; end
          CL_UNARY: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.op = opc; ctrl.zlow_in = 1'b1;
          end
          CL_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_en = 1'b1; end
          CL_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_en = 1'b1; end
          CL_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_en = 1'b1; end
          CL_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_LD, CL_LDI, CL_ST: begin ctrl.c_out = 1'b1; ctrl.op = ALU_ADD; ctrl.zlow_in = 1'b1; end
          CL_ALUR: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.op = opc; ctrl.zlow_in = 1'b1;
          end
          CL_ALUI: begin ctrl.c_out = 1'b1; ctrl.op = imm_op; ctrl.zlow_in = 1'b1; end
          CL_MULDIV: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.op = opc;
            ctrl.zlow_in = 1'b1; ctrl.zhigh_in = 1'b1;
          end
          CL_UNARY: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_BR:    begin ctrl.pc_out = 1'b1; ctrl.y_en = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_LD, CL_ST:              begin ctrl.zlow_out = 1'b1; ctrl.mar_en = 1'b1; end
          CL_LDI, CL_ALUR, CL_ALUI:  begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_MULDIV:                 begin ctrl.zlow_out = 1'b1; ctrl.lo_en = 1'b1; end
          CL_BR: begin ctrl.c_out = 1'b1; ctrl.op = ALU_ADD; ctrl.zlow_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CL_LD:     begin ctrl.mdr_read = 1'b1; ctrl.mdr_en = 1'b1; end
          CL_ST:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_en = 1'b1; end
          CL_MULDIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_en = 1'b1; end
          CL_BR:     begin ctrl.zlow_out = 1'b1; ctrl.pc_en = con_ff; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CL_LD:   begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CL_ST:   ctrl.ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign run            = (state_q != ST_RESET) && (state_q != ST_HALT);
  assign opCode         = ctrl.op;
  assign PCout          = ctrl.pc_out;
  assign ZLowout        = ctrl.zlow_out;
  assign ZHighout       = ctrl.zhigh_out;
  assign MDRout         = ctrl.mdr_out;
  assign HIout          = ctrl.hi_out;
  assign LOout          = ctrl.lo_out;
  assign InPortout      = ctrl.inport_out;
  assign BAout          = ctrl.ba_out;
  assign Cout           = ctrl.c_out;
  assign R_out          = ctrl.r_out;
  assign MAR_enable     = ctrl.mar_en;
  assign PC_enable      = ctrl.pc_en;
  assign MDR_enable     = ctrl.mdr_en;
  assign MDR_read       = ctrl.mdr_read;
  assign IR_enable      = ctrl.ir_en;
  assign Y_enable       = ctrl.y_en;
  assign ZLowIn         = ctrl.zlow_in;
  assign ZHighIn        = ctrl.zhigh_in;
  assign HI_enable      = ctrl.hi_en;
  assign LO_enable      = ctrl.lo_en;
  assign R_in           = ctrl.r_in;
  assign CON_enable     = ctrl.con_en;
  assign OutPort_enable = ctrl.outport_en;
  assign RAM_write      = ctrl.ram_write;
  assign IncPC          = ctrl.inc_pc;
  assign Gra            = ctrl.gra;
  assign Grb            = ctrl.grb;
  assign Grc            = ctrl.grc;

endmodule
